// File: rtl/cic_pkg.sv
// Sizing and arithmetic helpers shared by the multi-rate CIC interpolator.
package cic_pkg;

  localparam int MAX_STAGES = 6;

  function automatic int int_width(int in_w, int stages, int max_rate);
    return in_w + stages * $clog2(max_rate);
  endfunction

  // rate 0 behaves as 1; anything above max_rate pins to max_rate
  function automatic int clamp_rate(int r, int max_rate);
    if (r < 1) return 1;
    if (r > max_rate) return max_rate;
    return r;
  endfunction

  // Round-half-up arithmetic right shift; the 64-bit add cannot overflow for any legal width.
  function automatic longint round_shift(longint v, int sh);
    longint bias;
    bias = (sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0);
    return (v + bias) >>> sh;
  endfunction

  function automatic longint saturate(longint v, int out_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (out_w - 1)) - 1;
    lo = -(longint'(1) <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One modular integrator of the CIC cascade: q accumulates d whenever en is high.
module cic_integrator_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + d;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign q = acc_q;

endmodule

// File: rtl/cic_interp_mr.sv
// Multi-rate CIC interpolator: run-time rate, rounding output shift, valid/ready input with
// underrun stall, synchronous clear and a sticky saturation flag. Runs at the output rate.
module cic_interp_mr
  import cic_pkg::*;
#(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 4,
  parameter int STAGES    = 3,
  parameter int MAX_RATE  = 16,
  parameter int INT_WIDTH = int_width(IN_WIDTH, STAGES, MAX_RATE),
  localparam int PW = $clog2(MAX_RATE),
  localparam int RW = PW + 1,
  localparam int SW = $clog2(INT_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [RW-1:0]               rate,
  input  logic [SW-1:0]               shift,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        data_valid,
  output logic                        sat
);

  logic [PW-1:0]                    p_q, p_d;
  logic [RW-1:0]                    rate_q, rate_d, rate_cl, r_cur, p_nxt;
  logic [SW-1:0]                    shift_q, shift_d;
  logic [STAGES-1:0][INT_WIDTH-1:0] dly_q, dly_d, integ, integ_in;
  logic [INT_WIDTH-1:0]             comb_v;
  logic signed [OUT_WIDTH-1:0]      data_out_q, data_out_d;
  logic                             data_valid_q, data_valid_d, sat_q, sat_d;
  logic                             accept, run;
  longint                           v_rs, v_sat;

  // rst also masks in_ready so the block never advertises space while held in reset
  assign in_ready = enable && !clear && !rst && (p_q == '0);
  assign accept   = in_valid && in_ready;
  assign run      = enable && !clear && ((p_q != '0) || in_valid);

  // Comb chain at the base rate, evaluated only in the accept cycle; zero stuffing follows.
  always_comb begin
    comb_v = INT_WIDTH'(in_data);
    dly_d  = dly_q;
    for (int k = 0; k < STAGES; k++) begin
      if (accept) dly_d[k] = comb_v;
      comb_v = comb_v - dly_q[k];
    end
    if (clear) dly_d = '0;
    integ_in    = '0;
    integ_in[0] = accept ? comb_v : '0;
    for (int k = 1; k < STAGES; k++) integ_in[k] = integ[k-1];
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_int
      cic_integrator_stage #(.W(INT_WIDTH)) u_int (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .en  (run),
        .d   (integ_in[g]),
        .q   (integ[g])
      );
    end
  endgenerate

  // The accept cycle already belongs to the new frame, so its wrap test uses the new rate.
  always_comb begin
    rate_cl = RW'(clamp_rate(int'(rate), MAX_RATE));
    r_cur   = accept ? rate_cl : rate_q;
    p_nxt   = {1'b0, p_q} + RW'(1);
    rate_d  = r_cur;
    shift_d = accept ? shift : shift_q;
    p_d     = p_q;
    if (run) p_d = (p_nxt == r_cur) ? '0 : p_nxt[PW-1:0];
    if (clear) begin
      p_d     = '0;
      rate_d  = rate_cl;
      shift_d = shift;
    end
  end

  always_comb begin
    v_rs         = round_shift(longint'($signed(integ[STAGES-1])), int'(shift_q));
    v_sat        = saturate(v_rs, OUT_WIDTH);
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    sat_d        = sat_q;
    if (run) begin
      data_out_d   = OUT_WIDTH'(v_sat);
      data_valid_d = 1'b1;
      if (v_sat != v_rs) sat_d = 1'b1;
    end
    if (clear) begin
      data_out_d = '0;
      sat_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q          <= '0;
      rate_q       <= RW'(1);
      shift_q      <= '0;
      dly_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      p_q          <= p_d;
      rate_q       <= rate_d;
      shift_q      <= shift_d;
      dly_q        <= dly_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sat_q        <= sat_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign sat        = sat_q;

endmodule

// File: doc/cic_interp_mr.md
Name: cic_interp_mr

Overview:
- Parametrised multi-rate CIC interpolator, successor to the fixed-rate CIC feeding the MASH sigma-delta modulator.
- Adds the following:
  - run-time interpolation rate (1..MAX_RATE);
  - run-time output shift with round-half-up;
  - valid/ready input handshake with underrun stall;
  - synchronous state clear;
  - sticky saturation flag.
- Sits between the base-rate sample source and the MASH modulator.

Parameters:
IN_WIDTH, 4, signed input sample width
OUT_WIDTH, 4, signed output sample width
STAGES, 3, comb/integrator stage count (1..6)
MAX_RATE, 16, largest supported interpolation rate (power of 2, >=2)
INT_WIDTH, IN_WIDTH+STAGES*$clog2(MAX_RATE), internal accumulator width (default 16)

Ports:
clk  in  1  system clock (output sample rate)
rst  in  1  synchronous, active-high reset
enable  in  1  clock enable; low freezes all state
clear  in  1  synchronous flush of filter state and sat flag; config inputs unaffected
rate  in  $clog2(MAX_RATE)+1  interpolation rate R
shift  in  $clog2(INT_WIDTH)  output arithmetic right shift
in_data  in  IN_WIDTH  signed base-rate sample
in_valid  in  1  in_data valid
in_ready  out  1  block accepts a sample this cycle
data_out  out  OUT_WIDTH  signed interpolated sample
data_valid  out  1  data_out updated this cycle
sat  out  1  sticky: an output sample was clipped

Behaviour:
- Reset (rst=1 at posedge): clears all comb delays, integrators, phase counter and latched rate/shift (rate=1, shift=0). Outputs: data_out=0, data_valid=0, sat=0, in_ready=0 in the cycle after reset. Reset wins over clear and enable.
- clear=1 (enable irrelevant): same state clear as reset, except latched config is reloaded from the rate/shift ports. data_valid=0 that cycle.
- Phase counter p runs 0..R_lat-1. R_lat is latched from `rate` only on an accepted sample. rate=0 maps to 1; rate>MAX_RATE maps to MAX_RATE.
- in_ready = enable && !clear && p==0 (combinational).
- accept = in_valid && in_ready.
- run = enable && !clear && (p!=0 || in_valid). This is the advance qualifier.
- Stall: at p==0 with in_valid=0, no state changes and data_valid=0. The output rate therefore drops under underrun; no zero or hold samples are inserted.
- Comb section:
  - On accept only: sign-extend in_data to INT_WIDTH.
  - Pass it through a STAGES-deep differentiator chain, evaluated combinationally in the accept cycle. Each stage's delay register is updated on accept.
- Zero stuffing: integrator input x = comb result when p==0 (accept cycle), else 0.
- Integrators, on run:
  - I0 <= I0 + x.
  - Ik <= Ik + I(k-1), for k = 1..STAGES-1, using registered values.
- Arithmetic is modular two's complement at INT_WIDTH. Wrap-around is intentional and must not be trapped.
- Output, on run:
  - v = (I(STAGES-1) + (shift_lat>0 ? 1<<(shift_lat-1) : 0)) >>> shift_lat.
  - The rounding add is done at INT_WIDTH+1 bits.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and register into data_out.
  - data_valid <= 1.
  - sat <= 1 if clipped.
- shift_lat is latched with R_lat on accept.
- DC gain: R^(STAGES-1) before shift.
- Latency: the first nonzero data_out appears STAGES run-cycles after the accept cycle.
- Config changes mid-frame (p!=0) take effect at the next accept only.
- enable=0: everything holds, data_valid=0, data_out holds its value.

Decomposition:
- Package cic_pkg:
  - int_width(in_w, stages, max_rate) function;
  - rate clamp function;
  - saturate(value, out_w) function;
  - round-shift function.
- Sub-module cic_integrator_stage:
  - ports: clk, rst, clr, en, d (INT_WIDTH), q (INT_WIDTH);
  - instantiated STAGES times via generate.
- Comb chain stays inline.

Test Plan:
- DC step: R=4, STAGES=3, shift=4, OUT_WIDTH=4, in_data=3 held with in_valid=1 → settles to data_out=3 (3*16=48, 48>>4=3), sat=0.
- Impulse: OUT_WIDTH=8, R=4, shift=0, one sample 1 then zeros → consecutive outputs 1,3,6,10,12,12,10,6,3,1 then 0.
- Saturation: OUT_WIDTH=4, R=4, shift=0, in_data=7 held → data_out clips to 7 and sat=1. in_data=-8 held → -8. clear → sat=0.
- Underrun: deassert in_valid at p==0 for 5 cycles → in_ready stays 1, data_valid=0 for those 5 cycles, and the output sequence on resume matches the unstalled reference.
- Rate change: switch rate 4→8 while p=2 → the current frame finishes at 4 phases, the next frame has 8; rate=0 behaves as R=1 (in_ready every cycle).
- Reset/clear mid-frame: rst=1 at p=3 → next cycle data_out=0, data_valid=0, p=0. Same with clear=1 while rst=0, plus the new rate is latched.
